// File: rtl/txn_rr_arbiter.sv
// -----------------------------------------------------------------------------
// txn_rr_arbiter
//
// Round-robin arbiter sharing one downstream valid/ready/last transaction
// channel between NUM_REQ upstream requesters. A grant covers a whole
// multi-beat transaction; if the granted requester holds req_lock on its
// final beat, the grant also carries over into its next transaction
// (sequencer lock/grab behaviour).
//
// Ports
//   clk        : system clock, all logic on the rising edge
//   rst        : asynchronous, active-high reset
//   req_valid  : per-requester beat valid            [NUM_REQ]
//   req_data   : per-requester payload, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last   : per-requester final-beat marker     [NUM_REQ]
//   req_lock   : keep the grant after this transaction (sampled on last beat)
//   req_ready  : per-requester beat accept           [NUM_REQ]
//   out_valid  : downstream beat valid
//   out_data   : downstream payload
//   out_last   : downstream final-beat marker
//   out_src    : index of the granted requester
//   out_ready  : downstream beat accept
//   busy       : high while a grant is held
//   txn_count  : completed-transaction counter, wraps
// -----------------------------------------------------------------------------
module txn_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SRC_WIDTH  = $clog2(NUM_REQ),
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ-1:0]            req_lock,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  output logic [SRC_WIDTH-1:0]          out_src,
  input  logic                          out_ready,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          txn_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [SRC_WIDTH-1:0] grant_idx, grant_idx_nxt;
  logic [SRC_WIDTH-1:0] ptr, ptr_nxt;
  logic [SRC_WIDTH-1:0] sel_idx;
  logic                 sel_found;
  logic                 last_xfer;
  logic [CNT_WIDTH-1:0] cnt;

  // Increment modulo NUM_REQ; NUM_REQ need not be a power of two, so the
  // natural wrap of the index width cannot be relied on.
  function automatic logic [SRC_WIDTH-1:0] wrap_inc(input logic [SRC_WIDTH-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) return '0;
    else                          return idx + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Rotating priority search: first asserted req_valid starting at ptr.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [SRC_WIDTH-1:0] scan;
    // NOTE: every variable driven here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    sel_idx   = '0;
    sel_found = 1'b0;
    scan      = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!sel_found && req_valid[scan]) begin
        sel_idx   = scan;
        sel_found = 1'b1;
      end
      scan = wrap_inc(scan);
    end
  end

  // ---------------------------------------------------------------------------
  // Channel pass-through. Only the granted requester is connected; everything
  // reads zero while idle so downstream never sees stale data.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_src   = '0;
    busy      = 1'b0;
    if (state == GRANT) begin
      out_valid            = req_valid[grant_idx];
      out_data             = req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
      out_last             = req_last[grant_idx];
      out_src              = grant_idx;
      busy                 = 1'b1;
      req_ready[grant_idx] = out_ready;
    end
  end

  // A transaction completes on the handshake of its last beat. A stalled
  // channel (out_ready=0) never qualifies, so nothing advances during a stall.
  assign last_xfer = (state == GRANT) && out_valid && out_ready && out_last;

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    grant_idx_nxt = grant_idx;
    ptr_nxt       = ptr;
    unique case (state)
      IDLE: begin
        if (sel_found) begin
          grant_idx_nxt = sel_idx;
          state_nxt     = GRANT;
        end
      end
      GRANT: begin
        // Lock is only meaningful on the completing beat; a locked requester
        // keeps the channel with no bubble and the pointer stays put.
        if (last_xfer && !req_lock[grant_idx]) begin
          ptr_nxt   = wrap_inc(grant_idx);
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_idx <= '0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state     <= state_nxt;
      grant_idx <= grant_idx_nxt;
      ptr       <= ptr_nxt;
      if (last_xfer) cnt <= cnt + 1'b1;
    end
  end

  assign txn_count = cnt;

endmodule

// File: tb/tb_txn_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_txn_rr_arbiter
//
// Self-checking bench for txn_rr_arbiter: a directed vector table, hand
// sequences for multi-cycle corners (lock, stall, mid-transaction reset,
// counter wrap) and a randomized run against a behavioural model.
// A second instance with CNT_WIDTH=4 shares all inputs for the wrap check.
// -----------------------------------------------------------------------------
module tb_txn_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_lock;
  logic            out_ready;

  logic [N-1:0]    req_ready,  req_ready_w;
  logic            out_valid,  out_valid_w;
  logic [DW-1:0]   out_data,   out_data_w;
  logic            out_last,   out_last_w;
  logic [1:0]      out_src,    out_src_w;
  logic            busy,       busy_w;
  logic [15:0]     txn_count;
  logic [3:0]      txn_count_w;

  int n_checks = 0;
  int n_errors = 0;

  txn_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_lock(req_lock), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_src(out_src), .out_ready(out_ready), .busy(busy), .txn_count(txn_count)
  );

  txn_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_w (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_lock(req_lock), .req_ready(req_ready_w),
    .out_valid(out_valid_w), .out_data(out_data_w), .out_last(out_last_w),
    .out_src(out_src_w), .out_ready(out_ready), .busy(busy_w), .txn_count(txn_count_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [N-1:0]    v;
    logic [N-1:0]    l;
    logic [N-1:0]    k;
    logic            rdy;
    logic [N*DW-1:0] d;
    logic            e_ov;
    logic            e_ol;
    logic [1:0]      e_src;
    logic            e_busy;
    logic [DW-1:0]   e_od;
    logic [N-1:0]    e_rr;
    logic [15:0]     e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l,
                              input logic [3:0] k, input logic rdy,
                              input logic [127:0] d, input logic e_ov,
                              input logic e_ol, input logic [1:0] e_src,
                              input logic e_busy, input logic [31:0] e_od,
                              input logic [3:0] e_rr, input logic [15:0] e_cnt);
    vec_t r;
    r.v = v; r.l = l; r.k = k; r.rdy = rdy; r.d = d;
    r.e_ov = e_ov; r.e_ol = e_ol; r.e_src = e_src; r.e_busy = e_busy;
    r.e_od = e_od; r.e_rr = e_rr; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_d(input int i, input logic [DW-1:0] val);
    req_data[i*DW +: DW] = val;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [3:0] k);
    req_valid = v;
    req_last  = l;
    req_lock  = k;
  endtask

  // Reset and return at a falling edge with all inputs quiet.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(4'h0, 4'h0, 4'h0);
    req_data  = '0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Behavioural reference: whether a grant is held, to whom, the rotation
  // start point and the completed count, advanced once per clock.
  // -------------------------------------------------------------------------
  bit m_busy;
  int m_g;
  int m_ptr;
  int m_cnt;

  task automatic model_reset();
    m_busy = 0; m_g = 0; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic model_compare();
    logic [N-1:0]  e_rr;
    logic [DW-1:0] e_od;
    e_rr = '0;
    e_od = '0;
    if (m_busy) begin
      e_rr[m_g] = out_ready;
      e_od      = req_data[m_g*DW +: DW];
    end
    check("rnd_busy",  busy,      m_busy);
    check("rnd_valid", out_valid, m_busy ? req_valid[m_g] : 1'b0);
    check("rnd_last",  out_last,  m_busy ? req_last[m_g]  : 1'b0);
    check("rnd_src",   out_src,   m_busy ? m_g : 0);
    check("rnd_data",  out_data,  e_od);
    check("rnd_ready", req_ready, e_rr);
    check("rnd_cnt",   txn_count, m_cnt % 65536);
    check("rnd_cnt_w", txn_count_w, m_cnt % 16);
  endtask

  task automatic model_advance();
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        if (req_valid[(m_ptr + k) % N]) begin
          m_g    = (m_ptr + k) % N;
          m_busy = 1;
          break;
        end
      end
    end else if (req_valid[m_g] && out_ready && req_last[m_g]) begin
      m_cnt++;
      if (!req_lock[m_g]) begin
        m_ptr  = (m_g + 1) % N;
        m_busy = 0;
      end
    end
  endtask

  vec_t tbl[10];

  initial begin
    rst = 1'b1;
    drive(4'h0, 4'h0, 4'h0);
    req_data  = '0;
    out_ready = 1'b0;

    // ---------------- Table: requester 2 three beats, then pointer checks
    tbl[0] = mk(4'h4, 4'h0, 4'h0, 1'b1, {32'h0, 32'hA0, 64'h0}, 0, 0, 0, 0, 32'h0,  4'h0, 16'd0);
    tbl[1] = mk(4'h4, 4'h0, 4'h0, 1'b1, {32'h0, 32'hA0, 64'h0}, 1, 0, 2, 1, 32'hA0, 4'h4, 16'd0);
    tbl[2] = mk(4'h4, 4'h0, 4'h0, 1'b1, {32'h0, 32'hA1, 64'h0}, 1, 0, 2, 1, 32'hA1, 4'h4, 16'd0);
    tbl[3] = mk(4'h4, 4'h4, 4'h0, 1'b1, {32'h0, 32'hA2, 64'h0}, 1, 1, 2, 1, 32'hA2, 4'h4, 16'd0);
    tbl[4] = mk(4'h0, 4'h0, 4'h0, 1'b1, 128'h0,                 0, 0, 0, 0, 32'h0,  4'h0, 16'd1);
    tbl[5] = mk(4'h9, 4'h9, 4'h0, 1'b1, {32'hB3, 64'h0, 32'hB0}, 0, 0, 0, 0, 32'h0,  4'h0, 16'd1);
    tbl[6] = mk(4'h9, 4'h9, 4'h0, 1'b1, {32'hB3, 64'h0, 32'hB0}, 1, 1, 3, 1, 32'hB3, 4'h8, 16'd1);
    tbl[7] = mk(4'h1, 4'h1, 4'h0, 1'b1, {32'hB3, 64'h0, 32'hB0}, 0, 0, 0, 0, 32'h0,  4'h0, 16'd2);
    tbl[8] = mk(4'h1, 4'h1, 4'h0, 1'b1, {32'hB3, 64'h0, 32'hB0}, 1, 1, 0, 1, 32'hB0, 4'h1, 16'd2);
    tbl[9] = mk(4'h0, 4'h0, 4'h0, 1'b1, 128'h0,                 0, 0, 0, 0, 32'h0,  4'h0, 16'd3);

    #1;
    check("reset_valid", out_valid, 1'b0);
    check("reset_busy",  busy,      1'b0);
    check("reset_ready", req_ready, 4'h0);
    check("reset_cnt",   txn_count, 16'd0);

    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].l, tbl[i].k);
      out_ready = tbl[i].rdy;
      req_data  = tbl[i].d;
      #1;
      check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].e_ov);
      check($sformatf("tbl%0d_last",  i), out_last,  tbl[i].e_ol);
      check($sformatf("tbl%0d_src",   i), out_src,   tbl[i].e_src);
      check($sformatf("tbl%0d_busy",  i), busy,      tbl[i].e_busy);
      check($sformatf("tbl%0d_data",  i), out_data,  tbl[i].e_od);
      check($sformatf("tbl%0d_ready", i), req_ready, tbl[i].e_rr);
      check($sformatf("tbl%0d_cnt",   i), txn_count, tbl[i].e_cnt);
      @(negedge clk);
    end

    // ---------------- All four requesting single beats: order 0,1,2,3,0
    do_reset();
    drive(4'hF, 4'hF, 4'h0);
    for (int i = 0; i < N; i++) set_d(i, 32'hC0 + i);
    for (int c = 0; c < 10; c++) begin
      #1;
      if (c % 2 == 0) begin
        check("rr_idle_busy", busy, 1'b0);
        check("rr_idle_valid", out_valid, 1'b0);
      end else begin
        check("rr_src",  out_src,  (c / 2) % N);
        check("rr_data", out_data, 32'hC0 + (c / 2) % N);
        check("rr_busy", busy, 1'b1);
      end
      @(negedge clk);
    end
    drive(4'h0, 4'h0, 4'h0);
    #1;
    check("rr_cnt", txn_count, 16'd5);
    @(negedge clk);

    // ---------------- Lock: requester 1 two transactions back-to-back
    do_reset();
    drive(4'h1, 4'h1, 4'h0);       // single beat from 0 moves ptr to 1
    @(negedge clk);
    @(negedge clk);
    drive(4'h3, 4'h0, 4'h0); set_d(1, 32'hD0);
    #1; check("lock_idle", busy, 1'b0);
    @(negedge clk);
    #1; check("lock_src_a", out_src, 2'd1); check("lock_data_a", out_data, 32'hD0);
    @(negedge clk);
    drive(4'h3, 4'h2, 4'h2); set_d(1, 32'hD1);
    #1; check("lock_last_a", out_last, 1'b1); check("lock_src_b", out_src, 2'd1);
    @(negedge clk);
    drive(4'h3, 4'h0, 4'h0); set_d(1, 32'hD2);
    #1; check("lock_nobubble", busy, 1'b1); check("lock_src_c", out_src, 2'd1);
    check("lock_data_c", out_data, 32'hD2);
    @(negedge clk);
    drive(4'h3, 4'h2, 4'h0); set_d(1, 32'hD3);
    #1; check("lock_src_d", out_src, 2'd1); check("lock_cnt_d", txn_count, 16'd2);
    @(negedge clk);
    drive(4'h1, 4'h1, 4'h0);
    #1; check("lock_bubble", busy, 1'b0); check("lock_cnt_e", txn_count, 16'd3);
    @(negedge clk);
    #1; check("lock_then0", out_src, 2'd0); check("lock_then0_busy", busy, 1'b1);
    @(negedge clk);

    // ---------------- Stall: out_ready 1,0,0,1 over a two-beat transaction
    do_reset();
    drive(4'h1, 4'h0, 4'h0); set_d(0, 32'hE0);
    @(negedge clk);
    out_ready = 1'b1;
    #1; check("stall_rr1", req_ready, 4'h1); check("stall_d1", out_data, 32'hE0);
    @(negedge clk);
    drive(4'h1, 4'h1, 4'h0); set_d(0, 32'hE1); out_ready = 1'b0;
    #1; check("stall_rr2", req_ready, 4'h0); check("stall_d2", out_data, 32'hE1);
    check("stall_v2", out_valid, 1'b1);
    @(negedge clk);
    #1; check("stall_rr3", req_ready, 4'h0); check("stall_busy3", busy, 1'b1);
    check("stall_cnt3", txn_count, 16'd0);
    @(negedge clk);
    out_ready = 1'b1;
    #1; check("stall_rr4", req_ready, 4'h1); check("stall_cnt4", txn_count, 16'd0);
    @(negedge clk);
    drive(4'h0, 4'h0, 4'h0);
    #1; check("stall_cnt5", txn_count, 16'd1); check("stall_busy5", busy, 1'b0);
    @(negedge clk);

    // ---------------- Reset mid-transaction
    do_reset();
    drive(4'h4, 4'h4, 4'h0); set_d(2, 32'hF9);   // complete one, ptr -> 3
    @(negedge clk);
    #1; check("mrst_src2", out_src, 2'd2);
    @(negedge clk);
    drive(4'h8, 4'h0, 4'h0); set_d(3, 32'hF0);
    #1; check("mrst_cnt1", txn_count, 16'd1);
    @(negedge clk);
    #1; check("mrst_src3", out_src, 2'd3);
    @(negedge clk);
    set_d(3, 32'hF1);
    #1; check("mrst_d1", out_data, 32'hF1);
    #3 rst = 1'b1;
    #1;
    check("mrst_valid", out_valid, 1'b0);
    check("mrst_busy",  busy,      1'b0);
    check("mrst_cnt",   txn_count, 16'd0);
    check("mrst_ready", req_ready, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'hA, 4'hA, 4'h0);
    #1; check("mrst_idle", busy, 1'b0);
    @(negedge clk);
    #1; check("mrst_lowest", out_src, 2'd1);
    @(negedge clk);

    // ---------------- Counter wrap on the 4-bit instance
    do_reset();
    drive(4'h1, 4'h1, 4'h0);
    repeat (34) @(negedge clk);
    drive(4'h0, 4'h0, 4'h0);
    #1;
    check("wrap_cnt4",  txn_count_w, 4'd1);
    check("wrap_cnt16", txn_count,   16'd17);
    @(negedge clk);

    // ---------------- Randomized run against the model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        req_last[i]  = ($urandom_range(0, 2) == 0);
        req_lock[i]  = ($urandom_range(0, 3) == 0);
        set_d(i, $urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      model_compare();
      model_advance();
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/txn_rr_arbiter.md
Name: txn_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream transaction channel between NUM_REQ upstream requesters.
- Each requester presents multi-beat transactions on a valid/ready/last channel.
- A grant is held for the whole transaction. With lock asserted, it is also held across consecutive transactions, equivalent to a sequencer lock/grab.
- Sits between stimulus sources and a single shared driver-side interface.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 32, beat payload width
SRC_WIDTH, $clog2(NUM_REQ), width of source index output
CNT_WIDTH, 16, width of completed-transaction counter

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester beat valid
req_data  in  NUM_REQ*DATA_WIDTH  per-requester payload; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_last  in  NUM_REQ  final beat of a transaction
req_lock  in  NUM_REQ  keep grant after the current transaction ends
req_ready  out  NUM_REQ  per-requester beat accept
out_valid  out  1  downstream beat valid
out_data  out  DATA_WIDTH  downstream payload
out_last  out  1  downstream final beat
out_src  out  SRC_WIDTH  index of the granted requester
out_ready  in  1  downstream accept
busy  out  1  high whenever a grant is held
txn_count  out  CNT_WIDTH  count of completed transactions, wraps

Behaviour:
- Reset, asynchronous: state=IDLE, grant index g=0, priority pointer ptr=0, txn_count=0. All outputs read 0: out_valid, req_ready, busy, out_src, out_data, out_last.
- States are IDLE and GRANT.
- IDLE:
  - All req_ready=0, out_valid=0.
  - If any req_valid=1, select the first asserted requester scanning ptr, ptr+1, ..., wrapping mod NUM_REQ.
  - Register the selection as g and move to GRANT at the next edge. Arbitration latency is 1 cycle.
  - No requests: remain in IDLE.
- GRANT:
  - Combinational pass-through from requester g: out_valid=req_valid[g], out_data=requester g slice, out_last=req_last[g].
  - req_ready[g]=out_ready. req_ready of every other requester is 0.
  - out_src=g and busy=1, held stable for the whole grant.
- Beat transfer occurs when out_valid and out_ready are both 1.
- Transfer with out_last=1 completes a transaction: txn_count increments, wrapping from 2^CNT_WIDTH-1 to 0.
  - If req_lock[g]=1 in that same cycle: stay in GRANT with the same g; ptr is unchanged.
  - Otherwise: ptr = (g+1) mod NUM_REQ, go to IDLE.
- Exactly one idle cycle separates unlocked transactions. Locked back-to-back transactions have zero bubble.
- req_lock is sampled only on the last-beat transfer. Changes at any other time have no effect.
- req_valid[g] dropping mid-transaction: grant is held (no timeout), out_valid follows at 0.
- Requests arriving from other requesters during GRANT wait. They are never dropped and are considered at the next IDLE.
- Simultaneous requests in IDLE: ptr order decides, guaranteeing that each requester is served within NUM_REQ unlocked grants.
- out_ready=0 stalls the channel: data passes through unregistered, and no state or counter changes.
- Reset asserted mid-transaction:
  - Immediate return to reset values; the partial transaction is abandoned and not counted.
  - After deassertion, arbitration restarts from ptr=0.
- Single-beat transaction (req_last=1 on the first beat) is legal.

Test Plan:
- Reset, then only requester 2 sends 3 beats 0xA0,0xA1,0xA2 (last on third), out_ready=1 → grant in cycle after valid, out_src=2, beats in order, txn_count=1, busy drops, ptr=3.
- All 4 requesters valid continuously with single-beat transactions, lock=0 → grant order 0,1,2,3,0; one idle cycle between grants; txn_count=5.
- Requester 1 sends two 2-beat transactions with req_lock=1 on the first last-beat while requester 0 is also valid → both requester-1 transactions pass back-to-back with no bubble, then requester 0 is granted after one idle cycle.
- Requester 0 granted, out_ready toggles 1,0,0,1 during a 2-beat transaction → each beat accepted exactly once, req_ready[0]==out_ready, the other req_ready stay 0.
- Reset pulsed after beat 1 of a 3-beat transaction → out_valid=0, busy=0, txn_count=0 immediately; the next grant goes to the lowest valid index.
- CNT_WIDTH=4, 17 single-beat transactions → txn_count reads 1.
